// File: rtl/bus_mem_model_if.sv
// Core-side A/D bus bundle for the bus memory model.
// master = core/bench side, slave = memory responder side.
interface bus_mem_model_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              MREQ;
  logic              RD;
  logic              WR;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] D_IN;
  logic [DATA_W-1:0] D_OUT;
  logic              D_OE;
  logic              READY;
  logic [15:0]       RD_COUNT;
  logic [15:0]       WR_COUNT;
  logic              BUS_CONFLICT;
  logic              ROM_WR_ERR;

  modport master (
    output MREQ, RD, WR, A, D_IN,
    input  D_OUT, D_OE, READY,
    input  RD_COUNT, WR_COUNT,
    input  BUS_CONFLICT, ROM_WR_ERR
  );

  modport slave (
    input  MREQ, RD, WR, A, D_IN,
    output D_OUT, D_OE, READY,
    output RD_COUNT, WR_COUNT,
    output BUS_CONFLICT, ROM_WR_ERR
  );
endinterface

// File: rtl/bus_mem_model.sv
// SM83 bus memory responder: programmable read latency, strobe-edge writes.
// Optional write protection below ROM_TOP with BUS_MEM_ROM_PROTECT_EN.
module bus_mem_model #(
  parameter int          ADDR_W     = 16,
  parameter int          DATA_W     = 8,
  parameter int          RD_LATENCY = 1,
  parameter int unsigned ROM_TOP    = 'h7FFF,
  parameter int unsigned INIT_VAL   = 0
) (
  input logic           CLK,
  input logic           RESET_N,
  bus_mem_model_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR_HOLD
  } state_t;

  localparam logic [DATA_W-1:0] INIT = DATA_W'(INIT_VAL);
  localparam logic [3:0]        LAT  = 4'(RD_LATENCY);

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] dout_q;
  logic              oe_q;
  logic [15:0]       rd_cnt_q;
  logic [15:0]       wr_cnt_q;
  logic              conf_q;
  logic              rom_err_q;
  logic              rd_q;
  logic              wr_q;

  // Words are stored XOR INIT so power-up-zero storage reads as INIT_VAL.
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic rd_req;
  logic wr_req;
  logic rd_start;
  logic wr_start;
  logic conflict;
  logic latch;
  logic load_cnt;
  logic dec_cnt;
  logic drive;
  logic drop;
  logic rd_inc;
  logic sample;
  logic commit;
  logic rom_hit;
  logic wr_ok;
  logic [ADDR_W-1:0] rd_addr;

  assign rd_req   = bus.MREQ & bus.RD;
  assign wr_req   = bus.MREQ & bus.WR;
  assign conflict = bus.MREQ & bus.RD & bus.WR;
  assign rd_start = rd_req & ~rd_q;
  assign wr_start = wr_req & ~wr_q;

`ifdef BUS_MEM_ROM_PROTECT_EN
  assign rom_hit = addr_q <= ADDR_W'(ROM_TOP);
`else
  logic unused_rom;
  assign unused_rom = ^ADDR_W'(ROM_TOP);
  assign rom_hit    = 1'b0;
`endif

  assign wr_ok   = commit & ~rom_hit;
  assign rd_addr = (state_q == IDLE) ? bus.A : addr_q;

  // Next state and per-edge control strobes.
  always_comb begin
    state_d  = state_q;
    latch    = 1'b0;
    load_cnt = 1'b0;
    dec_cnt  = 1'b0;
    drive    = 1'b0;
    drop     = 1'b0;
    rd_inc   = 1'b0;
    sample   = 1'b0;
    commit   = 1'b0;
    if (conflict) begin
      state_d = IDLE;
      drop    = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rd_start) begin
            latch = 1'b1;
            if (LAT == 4'd0) begin
              state_d = RD_DRIVE;
              drive   = 1'b1;
            end else begin
              state_d  = RD_WAIT;
              load_cnt = 1'b1;
            end
          end else if (wr_start) begin
            latch   = 1'b1;
            sample  = 1'b1;
            state_d = WR_HOLD;
          end
        end
        RD_WAIT: begin
          if (!rd_req) begin
            state_d = IDLE;
          end else if (cnt_q == 4'd1) begin
            state_d = RD_DRIVE;
            drive   = 1'b1;
          end else begin
            dec_cnt = 1'b1;
          end
        end
        RD_DRIVE: begin
          if (!rd_req) begin
            state_d = IDLE;
            drop    = 1'b1;
            rd_inc  = 1'b1;
          end
        end
        WR_HOLD: begin
          if (wr_req) begin
            sample = 1'b1;
          end else begin
            state_d = IDLE;
            commit  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register, strobe history and access datapath.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      dout_q    <= '0;
      oe_q      <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      conf_q    <= 1'b0;
      rom_err_q <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_req;
      wr_q      <= wr_req;
      conf_q    <= conflict;
      rom_err_q <= commit & rom_hit;
      if (latch)    addr_q  <= bus.A;
      if (sample)   wdata_q <= bus.D_IN;
      if (load_cnt) cnt_q   <= LAT;
      else if (dec_cnt) cnt_q <= cnt_q - 4'd1;
      if (drive) begin
        dout_q <= mem[rd_addr] ^ INIT;
        oe_q   <= 1'b1;
      end else if (drop) begin
        oe_q   <= 1'b0;
      end
      if (rd_inc) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (wr_ok)  wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  // Memory array write port; contents survive reset.
  always_ff @(posedge CLK) begin
    if (wr_ok) mem[addr_q] <= wdata_q ^ INIT;
  end

  assign bus.D_OUT        = dout_q;
  assign bus.D_OE         = oe_q;
  assign bus.READY        = oe_q;
  assign bus.RD_COUNT     = rd_cnt_q;
  assign bus.WR_COUNT     = wr_cnt_q;
  assign bus.BUS_CONFLICT = conf_q;
  assign bus.ROM_WR_ERR   = rom_err_q;

endmodule

// File: tb/tb_bus_mem_model.sv
// Randomized bench for bus_mem_model against a transaction-level model.
// Protection expectations follow BUS_MEM_ROM_PROTECT_EN.
module tb_bus_mem_model;

  localparam int LAT = 3;
`ifdef BUS_MEM_ROM_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0]  mdl [int];
  logic [15:0] rd_cnt = '0;
  logic [15:0] wr_cnt = '0;

  bus_mem_model_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  bus_mem_model #(
    .ADDR_W    (16),
    .DATA_W    (8),
    .RD_LATENCY(LAT),
    .ROM_TOP   ('h7FFF),
    .INIT_VAL  (0)
  ) dut (
    .CLK    (clk),
    .RESET_N(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] mread(input logic [15:0] a);
    return mdl.exists(int'(a)) ? mdl[int'(a)] : 8'h00;
  endfunction

  task automatic idle();
    bus.MREQ = 1'b0;
    bus.RD   = 1'b0;
    bus.WR   = 1'b0;
  endtask

  task automatic rd_txn(input logic [15:0] a, input int extra);
    logic [7:0] exp;
    exp = mread(a);
    bus.A    = a;
    bus.MREQ = 1'b1;
    bus.RD   = 1'b1;
    step();
    for (int k = 1; k <= LAT; k++) begin
      chk("rd_wait_oe", 32'(bus.D_OE), 32'd0);
      bus.A = 16'($urandom);
      step();
    end
    chk("rd_oe", 32'(bus.D_OE), 32'd1);
    chk("rd_ready", 32'(bus.READY), 32'd1);
    chk("rd_data", 32'(bus.D_OUT), 32'(exp));
    for (int k = 0; k < extra; k++) begin
      bus.A = 16'($urandom);
      step();
      chk("rd_hold", 32'(bus.D_OUT), 32'(exp));
    end
    idle();
    step();
    rd_cnt++;
    chk("rd_end_oe", 32'(bus.D_OE), 32'd0);
    chk("rd_end_ready", 32'(bus.READY), 32'd0);
    chk("rd_count", 32'(bus.RD_COUNT), 32'(rd_cnt));
  endtask

  task automatic wr_txn(input logic [15:0] a, input int n,
                        input logic [7:0] d0, input logic [7:0] dl);
    bit hit;
    hit = PROT && (a <= 16'h7FFF);
    bus.A    = a;
    bus.D_IN = (n == 1) ? dl : d0;
    bus.MREQ = 1'b1;
    bus.WR   = 1'b1;
    step();
    for (int i = 1; i < n; i++) begin
      bus.A    = 16'($urandom);
      bus.D_IN = (i == n - 1) ? dl : d0;
      step();
    end
    idle();
    bus.D_IN = 8'($urandom);
    step();
    if (!hit) begin
      mdl[int'(a)] = dl;
      wr_cnt++;
    end
    chk("wr_count", 32'(bus.WR_COUNT), 32'(wr_cnt));
    chk("rom_err", 32'(bus.ROM_WR_ERR), 32'(hit));
    step();
    chk("rom_err_end", 32'(bus.ROM_WR_ERR), 32'd0);
  endtask

  task automatic abort_txn(input logic [15:0] a, input int h);
    bus.A    = a;
    bus.MREQ = 1'b1;
    bus.RD   = 1'b1;
    for (int i = 0; i < h; i++) begin
      step();
      chk("ab_oe", 32'(bus.D_OE), 32'd0);
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ab_idle_oe", 32'(bus.D_OE), 32'd0);
    end
    chk("ab_count", 32'(bus.RD_COUNT), 32'(rd_cnt));
  endtask

  task automatic conf_txn();
    bus.A    = 16'($urandom);
    bus.MREQ = 1'b1;
    bus.RD   = 1'b1;
    bus.WR   = 1'b1;
    step();
    chk("conf_pulse", 32'(bus.BUS_CONFLICT), 32'd1);
    chk("conf_oe", 32'(bus.D_OE), 32'd0);
    idle();
    step();
    chk("conf_end", 32'(bus.BUS_CONFLICT), 32'd0);
    chk("conf_rd", 32'(bus.RD_COUNT), 32'(rd_cnt));
    chk("conf_wr", 32'(bus.WR_COUNT), 32'(wr_cnt));
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h0100;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'hC000;
      5: return 16'hC123;
      6: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    bus.A    = '0;
    bus.D_IN = '0;
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.MREQ = 1'($urandom);
      bus.RD   = 1'($urandom);
      bus.WR   = 1'($urandom);
      bus.A    = 16'($urandom);
      step();
      chk("rst_oe", 32'(bus.D_OE), 32'd0);
      chk("rst_dout", 32'(bus.D_OUT), 32'd0);
      chk("rst_rdc", 32'(bus.RD_COUNT), 32'd0);
      chk("rst_pulses", 32'({bus.BUS_CONFLICT, bus.ROM_WR_ERR}), 32'd0);
    end
    idle();
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_oe", 32'(bus.D_OE), 32'd0);
    chk("post_rst_ready", 32'(bus.READY), 32'd0);

    wr_txn(16'hC000, 1, 8'h5A, 8'h5A);
    rd_txn(16'hC000, 2);
    wr_txn(16'hC123, 4, 8'hA7, 8'h3C);
    rd_txn(16'hC123, 0);
    abort_txn(16'hC000, 2);
    abort_txn(16'hC000, LAT);
    conf_txn();

    bus.A    = 16'hC000;
    bus.D_IN = 8'h11;
    bus.MREQ = 1'b1;
    bus.WR   = 1'b1;
    step();
    bus.RD = 1'b1;
    step();
    chk("wconf_pulse", 32'(bus.BUS_CONFLICT), 32'd1);
    idle();
    step();
    step();
    chk("wconf_wr", 32'(bus.WR_COUNT), 32'(wr_cnt));
    rd_txn(16'hC000, 0);

    wr_txn(16'h0100, 2, 8'hFF, 8'hFF);
    rd_txn(16'h0100, 1);

    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: rd_txn(pick_addr(), int'($urandom_range(0, 3)));
        4, 5, 6, 7: wr_txn(pick_addr(), int'($urandom_range(1, 4)),
                           8'($urandom), 8'($urandom));
        8: abort_txn(pick_addr(), int'($urandom_range(1, LAT)));
        default: conf_txn();
      endcase
      if ($urandom_range(0, 3) == 0) step();
    end

    bus.A    = 16'hC123;
    bus.MREQ = 1'b1;
    bus.RD   = 1'b1;
    for (int k = 0; k <= LAT; k++) step();
    chk("pre_rst_oe", 32'(bus.D_OE), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_oe", 32'(bus.D_OE), 32'd0);
    chk("async_rst_ready", 32'(bus.READY), 32'd0);
    chk("async_rst_rdc", 32'(bus.RD_COUNT), 32'd0);
    chk("async_rst_wrc", 32'(bus.WR_COUNT), 32'd0);
    rd_cnt = '0;
    wr_cnt = '0;
    idle();
    step();
    rst_n = 1'b1;
    step();
    chk("rel_oe", 32'(bus.D_OE), 32'd0);
    rd_txn(16'hC123, 0);
    rd_txn(16'hC000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
